// File: rtl/main_decoder_fsm_if.sv
// Bus between the instruction register / datapath and the main decoder FSM.
// master: IR side (drives Op/Funct/Rd); slave: decoder (drives all strobes).
interface main_decoder_fsm_if #(
    parameter int STATE_W = 4
);
    logic [1:0]         Op;
    logic [5:0]         Funct;
    logic [3:0]         Rd;
    logic               IRWrite;
    logic               NextPC;
    logic               AdrSrc;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ResultSrc;
    logic               RegW;
    logic               MemW;
    logic               Branch;
    logic               PCS;
    logic [1:0]         ALUControl;
    logic [1:0]         FlagW;
    logic [1:0]         ImmSrc;
    logic [1:0]         RegSrc;
    logic [STATE_W-1:0] State;

    modport master (
        output Op, Funct, Rd,
        input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
        input  RegW, MemW, Branch, PCS, ALUControl, FlagW,
        input  ImmSrc, RegSrc, State
    );

    modport slave (
        input  Op, Funct, Rd,
        output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
        output RegW, MemW, Branch, PCS, ALUControl, FlagW,
        output ImmSrc, RegSrc, State
    );
endinterface

// File: rtl/main_decoder_fsm.sv
// Multicycle control FSM + ALU decoder for the ARM-subset core.
// Ports: clk, reset (async active-low), bus (slave): IR fields in, strobes/selects/State out.
module main_decoder_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    main_decoder_fsm_if.slave  bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic       aluop;
    logic       regw;
    logic       legal;
    logic [1:0] alu_ctl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = FETCH;
        bus.IRWrite   = 1'b0;
        bus.NextPC    = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 2'b00;
        bus.ResultSrc = 2'b00;
        regw          = 1'b0;
        bus.MemW      = 1'b0;
        bus.Branch    = 1'b0;
        aluop         = 1'b0;
        case (state_q)
            FETCH: begin
                state_d       = DECODE;
                bus.IRWrite   = 1'b1;
                bus.NextPC    = 1'b1;
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            DECODE: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                unique case (bus.Op)
                    2'b00: state_d = bus.Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01: state_d = MEMADR;
                    2'b10: state_d = BRANCH;
                    2'b11: state_d = FETCH;
                endcase
            end
            MEMADR: begin
                state_d     = bus.Funct[0] ? MEMRD : MEMWR;
                bus.ALUSrcB = 2'b01;
            end
            MEMRD: begin
                state_d    = MEMWB;
                bus.AdrSrc = 1'b1;
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                regw          = 1'b1;
            end
            MEMWR: begin
                bus.AdrSrc = 1'b1;
                bus.MemW   = 1'b1;
            end
            EXECUTER: begin
                state_d = ALUWB;
                aluop   = 1'b1;
            end
            EXECUTEI: begin
                state_d     = ALUWB;
                bus.ALUSrcB = 2'b01;
                aluop       = 1'b1;
            end
            ALUWB: regw = 1'b1;
            BRANCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                bus.Branch    = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Unknown cmds fall back to ADD and must never touch the flags.
    always_comb begin
        legal   = 1'b1;
        alu_ctl = 2'b00;
        unique case (bus.Funct[4:1])
            4'b0100: alu_ctl = 2'b00;
            4'b0010: alu_ctl = 2'b01;
            4'b0000: alu_ctl = 2'b10;
            4'b1100: alu_ctl = 2'b11;
            default: legal   = 1'b0;
        endcase
    end

    assign bus.ALUControl = aluop ? alu_ctl : 2'b00;
    assign bus.FlagW[1]   = aluop & legal & bus.Funct[0];
    assign bus.FlagW[0]   = aluop & legal & bus.Funct[0] & ~alu_ctl[1];

    assign bus.RegW   = regw;
    assign bus.PCS    = regw & (bus.Rd == 4'hF);
    assign bus.ImmSrc = bus.Op;
    assign bus.RegSrc = {bus.Op == 2'b01, bus.Op == 2'b10};
    assign bus.State  = STATE_W'(state_q);

endmodule

// File: tb/tb_main_decoder_fsm.sv
// Scoreboard bench for main_decoder_fsm: stimulus pushes expected cycles,
// a negedge monitor pops and compares them against the DUT.
module tb_main_decoder_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       irw;
        logic       npc;
        logic       adr;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic       regw;
        logic       memw;
        logic       br;
        logic       pcs;
        logic [1:0] aluc;
        logic [1:0] flagw;
        logic [1:0] imm;
        logic [1:0] regsrc;
    } vec_t;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    vec_t sb[$];

    main_decoder_fsm_if #(.STATE_W(4)) bus();

    main_decoder_fsm #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction class -> list of visited state codes.
    function automatic void seq_of(input logic [1:0] op, input logic [5:0] f,
                                   output int s[5], output int n);
        s = '{0, 1, 0, 0, 0};
        case (op)
            2'd0: begin s[2] = f[5] ? 7 : 6; s[3] = 8; n = 4; end
            2'd1: begin
                s[2] = 2;
                if (f[0]) begin s[3] = 3; s[4] = 4; n = 5; end
                else begin s[3] = 5; n = 4; end
            end
            2'd2: begin s[2] = 9; n = 3; end
            default: n = 2;
        endcase
    endfunction

    // Expected outputs for one cycle spent in state code st.
    function automatic vec_t expect_of(input int st, input logic [1:0] op,
                                       input logic [5:0] f, input logic [3:0] rd);
        vec_t v;
        bit   alu;
        bit   arith;
        bit   ok;
        v = '0;
        alu = 0;
        v.st = 4'(st);
        v.imm = op;
        v.regsrc = {op == 2'd1, op == 2'd2};
        case (st)
            0: begin v.irw = 1; v.npc = 1; v.srca = 1; v.srcb = 2; v.res = 2; end
            1: begin v.srca = 1; v.srcb = 2; v.res = 2; end
            2: v.srcb = 1;
            3: v.adr = 1;
            4: begin v.res = 1; v.regw = 1; end
            5: begin v.adr = 1; v.memw = 1; end
            6: alu = 1;
            7: begin v.srcb = 1; alu = 1; end
            8: v.regw = 1;
            9: begin v.srcb = 1; v.res = 2; v.br = 1; end
            default: ;
        endcase
        if (alu) begin
            ok = 1;
            arith = 0;
            if (f[4:1] == 4'd4) begin v.aluc = 0; arith = 1; end
            else if (f[4:1] == 4'd2) begin v.aluc = 1; arith = 1; end
            else if (f[4:1] == 4'd0) v.aluc = 2;
            else if (f[4:1] == 4'd12) v.aluc = 3;
            else ok = 0;
            v.flagw = {f[0] & ok, f[0] & ok & arith};
        end
        v.pcs = v.regw && (rd == 4'hF);
        return v;
    endfunction

    task automatic run_instr(input logic [1:0] op, input logic [5:0] f,
                             input logic [3:0] rd, input int cut);
        int s[5];
        int n;
        seq_of(op, f, s, n);
        if (cut >= 0 && cut < n) n = cut + 1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                bus.Op = op;
                bus.Funct = f;
                bus.Rd = rd;
                reset = 1'b1;
            end
            sb.push_back(expect_of(s[i], op, f, rd));
        end
    endtask

    task automatic hold_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            sb.push_back(expect_of(0, bus.Op, bus.Funct, bus.Rd));
        end
    endtask

    task automatic check1(input string name, input logic [3:0] got, input logic [3:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Monitor
    initial begin
        vec_t e;
        vec_t a;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a.st = bus.State;
                a.irw = bus.IRWrite;
                a.npc = bus.NextPC;
                a.adr = bus.AdrSrc;
                a.srca = bus.ALUSrcA;
                a.srcb = bus.ALUSrcB;
                a.res = bus.ResultSrc;
                a.regw = bus.RegW;
                a.memw = bus.MemW;
                a.br = bus.Branch;
                a.pcs = bus.PCS;
                a.aluc = bus.ALUControl;
                a.flagw = bus.FlagW;
                a.imm = bus.ImmSrc;
                a.regsrc = bus.RegSrc;
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL vec t=%0t state got %0d want %0d: outputs got %h want %h",
                             $time, a.st, e.st, a, e);
                end
            end
        end
    end

    // Stimulus
    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0;
        bus.Op = 2'd0;
        bus.Funct = 6'd0;
        bus.Rd = 4'd0;
        hold_reset(3);

        run_instr(2'b00, 6'b001001, 4'd1, -1);
        run_instr(2'b00, 6'b000100, 4'hF, -1);
        run_instr(2'b01, 6'b011001, 4'd3, -1);
        run_instr(2'b01, 6'b011000, 4'hF, -1);
        run_instr(2'b10, 6'b100000, 4'hF, -1);
        run_instr(2'b11, 6'b111111, 4'hF, -1);
        run_instr(2'b00, 6'b001111, 4'd2, -1);
        run_instr(2'b00, 6'b011001, 4'd4, -1);

        // Abort an instruction in EXECUTER with an async reset.
        run_instr(2'b00, 6'b000100, 4'hF, 2);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check1("async_state", bus.State, 4'd0);
        check1("async_irwrite", {3'b0, bus.IRWrite}, 4'd1);
        check1("async_nextpc", {3'b0, bus.NextPC}, 4'd1);
        check1("async_regw", {3'b0, bus.RegW}, 4'd0);
        hold_reset(3);
        run_instr(2'b00, 6'b101001, 4'd5, -1);

        for (int k = 0; k < 80; k++) begin
            logic [1:0] op;
            logic [5:0] f;
            logic [3:0] rd;
            op = 2'($urandom_range(0, 3));
            f = 6'($urandom);
            if (($urandom & 1) == 1) begin
                case ($urandom_range(0, 3))
                    0: f[4:1] = 4'd4;
                    1: f[4:1] = 4'd2;
                    2: f[4:1] = 4'd0;
                    default: f[4:1] = 4'd12;
                endcase
            end
            rd = (($urandom & 3) == 0) ? 4'hF : 4'($urandom);
            run_instr(op, f, rd, -1);
        end

        repeat (4) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
